// File: rtl/port_supervisor.sv
// Port supervisor for QSFP/HDMI cages: presence debounce, module reset sequencing,
// hot-plug qualification and status LEDs. Each channel runs independently of the others.
module port_supervisor #(
   parameter int CHANNELS            = 2,
   parameter int CLOCK_FREQUENCY     = 200_000_000,
   parameter int BLINK_HZ            = 1,
   parameter int DEBOUNCE_CYCLES     = 1_000_000,
   parameter int MODULE_RESET_CYCLES = 2_000,
   parameter int STARTUP_CYCLES      = 200_000,
   parameter int LED_ACTIVE_LOW      = 1
) (
   input  logic                system_clock,
   input  logic                system_reset,
   input  logic [CHANNELS-1:0] modprsl,
   input  logic [CHANNELS-1:0] run,
   input  logic [CHANNELS-1:0] restart,
   output logic [CHANNELS-1:0] resetl,
   output logic [CHANNELS-1:0] channel_reset,
   output logic [CHANNELS-1:0] hpd,
   output logic [CHANNELS:0]   led
);

   localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TMR_MAX  = (MODULE_RESET_CYCLES > STARTUP_CYCLES) ? MODULE_RESET_CYCLES
                                                                    : STARTUP_CYCLES;
   localparam int TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam int HALF_RAW = CLOCK_FREQUENCY / (2 * BLINK_HZ);
   localparam int HALF     = (HALF_RAW > 1) ? HALF_RAW : 1;
   localparam int BL_W     = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(MODULE_RESET_CYCLES - 1);
   localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(STARTUP_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
   localparam logic [BL_W-1:0]  BL_LAST   = BL_W'(HALF - 1);
   localparam logic [BL_W-1:0]  BL_ONE    = BL_W'(1);
   localparam logic             LED_INV   = (LED_ACTIVE_LOW != 0);

   typedef enum logic [1:0] {ST_ABSENT, ST_HOLD, ST_WAIT, ST_ACTIVE} state_t;

   logic [CHANNELS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [CHANNELS-1:0] present_db_q, present_db_d;
   logic [DB_W-1:0]     db_cnt_q [CHANNELS];
   logic [DB_W-1:0]     db_cnt_d [CHANNELS];
   state_t              state_q  [CHANNELS];
   state_t              state_d  [CHANNELS];
   logic [TMR_W-1:0]    tmr_q    [CHANNELS];
   logic [TMR_W-1:0]    tmr_d    [CHANNELS];
   logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
   logic                blink_phase_q, blink_phase_d;
   logic                alive_q, alive_d;
   logic [CHANNELS-1:0] port_lit;

   // Presence is synchronised, then must hold a new level for DEBOUNCE_CYCLES samples.
   always_comb begin
      sync1_d      = ~modprsl;
      sync2_d      = sync1_q;
      present_db_d = present_db_q;
      for (int i = 0; i < CHANNELS; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != present_db_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               present_db_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
            end
         end
      end
   end

   // Removal outranks restart; restart is meaningless while no module is seated.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i] = state_q[i];
         tmr_d[i]   = tmr_q[i] + TMR_ONE;
         if (!present_db_q[i]) begin
            state_d[i] = ST_ABSENT;
            tmr_d[i]   = '0;
         end else if (restart[i] && (state_q[i] != ST_ABSENT)) begin
            state_d[i] = ST_HOLD;
            tmr_d[i]   = '0;
         end else begin
            case (state_q[i])
               ST_ABSENT: begin
                  state_d[i] = ST_HOLD;
                  tmr_d[i]   = '0;
               end
               ST_HOLD: begin
                  if (tmr_q[i] == HOLD_LAST) begin
                     state_d[i] = ST_WAIT;
                     tmr_d[i]   = '0;
                  end
               end
               ST_WAIT: begin
                  if (tmr_q[i] == WAIT_LAST) begin
                     state_d[i] = ST_ACTIVE;
                     tmr_d[i]   = '0;
                  end
               end
               ST_ACTIVE: tmr_d[i] = '0;
            endcase
         end
      end
   end

   always_comb begin
      blink_cnt_d   = blink_cnt_q + BL_ONE;
      blink_phase_d = blink_phase_q;
      if (blink_cnt_q == BL_LAST) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end
      alive_d = ~system_reset;
   end

   always_comb begin
      resetl        = '0;
      channel_reset = '1;
      hpd           = '0;
      port_lit      = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         resetl[i]        = (state_q[i] == ST_WAIT) || (state_q[i] == ST_ACTIVE);
         channel_reset[i] = (state_q[i] != ST_ACTIVE);
         hpd[i]           = (state_q[i] == ST_ACTIVE);
         if (state_q[i] == ST_ACTIVE && run[i]) begin
            port_lit[i] = 1'b1;
         end else if (state_q[i] != ST_ABSENT) begin
            port_lit[i] = blink_phase_q;
         end
      end
   end

   assign led = {alive_q, port_lit} ^ {(CHANNELS + 1){LED_INV}};

   always_ff @(posedge system_clock) begin
      if (system_reset) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         present_db_q  <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         alive_q       <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            db_cnt_q[i] <= '0;
            state_q[i]  <= ST_ABSENT;
            tmr_q[i]    <= '0;
         end
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         present_db_q  <= present_db_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         alive_q       <= alive_d;
         for (int i = 0; i < CHANNELS; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
            state_q[i]  <= state_d[i];
            tmr_q[i]    <= tmr_d[i];
         end
      end
   end

endmodule

// File: tb/tb_port_supervisor.sv
// Scoreboard bench for port_supervisor: scenarios queue timed expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_port_supervisor;

   logic       system_clock = 1'b0;
   logic       system_reset;
   logic [1:0] modprsl, run, restart;
   logic [1:0] resetl, channel_reset, hpd;
   logic [2:0] led;

   port_supervisor #(
      .CHANNELS(2), .CLOCK_FREQUENCY(10), .BLINK_HZ(1), .DEBOUNCE_CYCLES(4),
      .MODULE_RESET_CYCLES(8), .STARTUP_CYCLES(3), .LED_ACTIVE_LOW(1)
   ) dut (
      .system_clock (system_clock),
      .system_reset (system_reset),
      .modprsl      (modprsl),
      .run          (run),
      .restart      (restart),
      .resetl       (resetl),
      .channel_reset(channel_reset),
      .hpd          (hpd),
      .led          (led)
   );

   always #5 system_clock = ~system_clock;

   typedef struct {
      int         cyc;
      int         sel;
      logic [2:0] val;
      string      tag;
   } exp_t;

   exp_t sb_q[$];
   int   cyc     = 0;
   int   rst_cyc = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always @(posedge system_clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge system_clock) begin
      exp_t       e;
      logic [2:0] obs;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         e = sb_q.pop_front();
         case (e.sel)
            0:       obs = {1'b0, resetl};
            1:       obs = {1'b0, channel_reset};
            2:       obs = {1'b0, hpd};
            default: obs = led;
         endcase
         if (e.cyc != cyc) chk({e.tag, ".late"}, cyc, e.cyc);
         else              chk(e.tag, {29'd0, obs}, {29'd0, e.val});
      end
   end

   task automatic push(input int k, input int sel, input logic [2:0] val, input string tag);
      exp_t e;
      int   i;
      e.cyc = k;
      e.sel = sel;
      e.val = val;
      e.tag = tag;
      i = sb_q.size();
      while (i > 0 && sb_q[i-1].cyc > k) i--;
      sb_q.insert(i, e);
   endtask

   task automatic push_out(input int k, input logic [1:0] rl, input logic [1:0] cr,
                           input logic [1:0] hp, input string tag);
      push(k, 0, {1'b0, rl}, {tag, ".resetl"});
      push(k, 1, {1'b0, cr}, {tag, ".chrst"});
      push(k, 2, {1'b0, hp}, {tag, ".hpd"});
   endtask

   // Blink phase after edge k: toggles every 5 edges counted from the last reset edge.
   function automatic logic ph(input int k);
      return (((k - rst_cyc) / 5) % 2) == 1;
   endfunction

   // mode: 0 dark, 1 blinking, 2 steadily lit; active-low LED level returned.
   function automatic logic led_bit(input int k, input int mode);
      logic lit;
      lit = (mode == 2) || (mode == 1 && ph(k));
      return ~lit;
   endfunction

   task automatic push_led(input int k, input int m0, input int m1, input string tag);
      push(k, 3, {1'b0, led_bit(k, m1), led_bit(k, m0)}, {tag, ".led"});
   endtask

   task automatic drv();
      @(negedge system_clock);
      #1;
   endtask

   task automatic wait_to(input int k);
      while (cyc < k) drv();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int c;
      int budget;
      system_reset = 1'b1;
      modprsl      = 2'b11;
      run          = 2'b00;
      restart      = 2'b00;

      // Reset state
      wait_to(2);
      push_out(3, 2'b00, 2'b11, 2'b00, "rst");
      push(3, 3, 3'b111, "rst.led");
      wait_to(3);
      system_reset = 1'b0;
      rst_cyc      = 3;
      push_led(4, 0, 0, "alive");

      // Channel 0 insertion: debounce, hold, startup, active
      wait_to(6);
      c = cyc;
      modprsl[0] = 1'b0;
      push_out(c + 14, 2'b00, 2'b11, 2'b00, "a_hold");
      push_led(c + 8, 1, 0, "a_hold8");
      push_led(c + 12, 1, 0, "a_hold12");
      push_out(c + 15, 2'b01, 2'b11, 2'b00, "a_wait");
      push_out(c + 17, 2'b01, 2'b11, 2'b00, "a_wait_end");
      push_out(c + 18, 2'b01, 2'b10, 2'b01, "a_active");
      push_led(c + 19, 1, 0, "a_norun");
      wait_to(c + 20);

      // Channel 1 glitch shorter than the debounce window
      c = cyc;
      modprsl[1] = 1'b0;
      push_out(c + 8, 2'b01, 2'b10, 2'b01, "b8");
      push_out(c + 15, 2'b01, 2'b10, 2'b01, "b15");
      push_out(c + 20, 2'b01, 2'b10, 2'b01, "b20");
      for (int k = c + 4; k <= c + 15; k++) push_led(k, 1, 0, "b_blink");
      wait_to(c + 3);
      modprsl[1] = 1'b1;
      wait_to(c + 21);

      // Run: lit steady on active channel 0, ignored on absent channel 1
      c = cyc;
      run = 2'b11;
      for (int k = c + 1; k <= c + 10; k += 3) push_led(k, 2, 0, "run");
      wait_to(c + 11);
      run = 2'b00;

      // Restart of active channel 0; restart of absent channel 1 ignored
      wait_to(cyc + 2);
      c = cyc;
      restart = 2'b11;
      push_out(c + 1, 2'b00, 2'b11, 2'b00, "rs_hold");
      push_led(c + 2, 1, 0, "rs_led2");
      push_led(c + 7, 1, 0, "rs_led7");
      push_out(c + 8, 2'b00, 2'b11, 2'b00, "rs_hold_end");
      push_out(c + 9, 2'b01, 2'b11, 2'b00, "rs_wait");
      push_out(c + 11, 2'b01, 2'b11, 2'b00, "rs_wait_end");
      push_out(c + 12, 2'b01, 2'b10, 2'b01, "rs_active");
      wait_to(c + 1);
      restart = 2'b00;
      wait_to(c + 14);

      // Removal of channel 0 with restart on the edge the FSM sees it gone
      c = cyc;
      modprsl[0] = 1'b1;
      push_out(c + 6, 2'b01, 2'b10, 2'b01, "pf_still");
      push_out(c + 7, 2'b00, 2'b11, 2'b00, "pf_absent");
      push_led(c + 8, 0, 0, "pf_led8");
      push_led(c + 13, 0, 0, "pf_led13");
      push_out(c + 16, 2'b00, 2'b11, 2'b00, "pf_no_wait");
      wait_to(c + 6);
      restart = 2'b01;
      wait_to(c + 7);
      restart = 2'b00;
      wait_to(c + 18);

      // System reset while channel 0 is in WAIT, then full re-qualification
      c = cyc;
      modprsl[0] = 1'b0;
      push_out(c + 16, 2'b01, 2'b11, 2'b00, "r_wait");
      push_led(c + 16, 1, 0, "r_wait_led");
      wait_to(c + 16);
      system_reset = 1'b1;
      push_out(c + 17, 2'b00, 2'b11, 2'b00, "r_rst");
      push(c + 17, 3, 3'b111, "r_rst.led");
      wait_to(c + 17);
      system_reset = 1'b0;
      rst_cyc      = c + 17;
      push_out(c + 18, 2'b00, 2'b11, 2'b00, "r_noactive");
      push_led(c + 18, 0, 0, "r_alive");
      push_led(c + 26, 1, 0, "r_hold_led");
      push_out(c + 31, 2'b00, 2'b11, 2'b00, "r_hold_end");
      push_out(c + 32, 2'b01, 2'b11, 2'b00, "r_wait2");
      push_out(c + 34, 2'b01, 2'b11, 2'b00, "r_wait2_end");
      push_out(c + 35, 2'b01, 2'b10, 2'b01, "r_active2");

      budget = 0;
      while (sb_q.size() > 0 && budget < 200) begin
         drv();
         budget++;
      end
      if (sb_q.size() != 0) chk("drain", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/port_supervisor.md
PORT_SUPERVISOR -- requirements
Module: port_supervisor

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of supervised QSFP/HDMI ports (1..8).
REQ-002 SHALL have parameter CLOCK_FREQUENCY, default 200_000_000, system_clock rate in Hz.
REQ-003 SHALL have parameter BLINK_HZ, default 1, LED blink rate.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, modprsl stability window (>=1).
REQ-005 SHALL have parameter MODULE_RESET_CYCLES, default 2_000, resetl low time (>=1).
REQ-006 SHALL have parameter STARTUP_CYCLES, default 200_000, wait after resetl release (>=1).
REQ-007 SHALL have parameter LED_ACTIVE_LOW, default 1, LED lit level is 0 when 1.
REQ-008 SHALL have port system_clock  input  1  sole clock; all logic on its rising edge.
REQ-009 SHALL have port system_reset  input  1  synchronous, active-high reset.
REQ-010 SHALL have port modprsl  input  CHANNELS  asynchronous module-present, active-low.
REQ-011 SHALL have port run  input  CHANNELS  per-channel "video running" status.
REQ-012 SHALL have port restart  input  CHANNELS  single-cycle pulse requesting port re-init.
REQ-013 SHALL have port resetl  output  CHANNELS  module reset, active-low.
REQ-014 SHALL have port channel_reset  output  CHANNELS  active-high reset to channel logic.
REQ-015 SHALL have port hpd  output  CHANNELS  debounced, qualified hot-plug detect.
REQ-016 SHALL have port led  output  CHANNELS+1  bit CHANNELS = alive, bits [CHANNELS-1:0] = per-port.

Function
REQ-017 SHALL pass each ~modprsl bit through a 2-flop synchroniser before any use.
REQ-018 SHALL keep per-channel present_db and counter: counter clears while synced == present_db, else increments; on mismatch with counter == DEBOUNCE_CYCLES-1, present_db takes synced and counter clears.
REQ-019 SHALL thus update present_db exactly DEBOUNCE_CYCLES+2 edges after the first edge sampling a stable new level; shorter pulses never change present_db.
REQ-020 SHALL run a per-channel FSM ABSENT, HOLD, WAIT, ACTIVE with one shared-width cycle counter per channel.
REQ-021 SHALL transition ABSENT->HOLD on the edge present_db is 1, counter cleared.
REQ-022 SHALL stay in HOLD exactly MODULE_RESET_CYCLES cycles, then WAIT, counter cleared.
REQ-023 SHALL stay in WAIT exactly STARTUP_CYCLES cycles, then ACTIVE.
REQ-024 SHALL go from any state to ABSENT on the edge present_db is 0; this outranks restart.
REQ-025 SHALL, on restart in HOLD/WAIT/ACTIVE with present_db 1, enter HOLD with counter cleared; restart in ABSENT is ignored.
REQ-026 SHALL decode outputs from registered state: resetl=0 in ABSENT/HOLD else 1; channel_reset=0 only in ACTIVE; hpd=1 only in ACTIVE.
REQ-027 SHALL generate one shared blink phase toggling every CLOCK_FREQUENCY/(2*BLINK_HZ) cycles (counter wraps to 0 on toggle).
REQ-028 SHALL drive per-port LED lit when ACTIVE and run; blinking (lit when phase 1) in HOLD/WAIT, or ACTIVE without run; dark in ABSENT.
REQ-029 SHALL ignore run in all states except ACTIVE.
REQ-030 SHALL register alive LED as lit = ~system_reset, one cycle latency.
REQ-031 SHALL apply LED_ACTIVE_LOW inversion to all led bits; channels operate fully independently.

Reset
REQ-032 SHALL, on any edge with system_reset high, force all FSMs to ABSENT, all counters and present_db to 0, synchronisers to 0, blink phase to 0.
REQ-033 SHALL give reset outputs: resetl all 0, channel_reset all 1, hpd all 0, all LEDs dark at the next edge.
REQ-034 SHALL apply reset mid-operation identically, regardless of state or counter value.

Verification (CHANNELS=2, CLOCK_FREQUENCY=10, BLINK_HZ=1, DEBOUNCE_CYCLES=4, MODULE_RESET_CYCLES=8, STARTUP_CYCLES=3, LED_ACTIVE_LOW=1)
REQ-035 SHALL cover: modprsl[0] falls, held -> present_db after 6 edges, resetl[0] 0 for 8 cycles, then channel_reset[0]=0 and hpd[0]=1 exactly 3 cycles later; channel 1 untouched.
REQ-036 SHALL cover: modprsl[1] low for 3 cycles then high -> hpd[1], resetl[1] stay 0, FSM stays ABSENT.
REQ-037 SHALL cover: channel 0 ACTIVE, restart[0] pulse -> resetl[0]=0 and hpd[0]=0 next edge, full 8+3 sequence repeats.
REQ-038 SHALL cover: restart[0] on same edge present_db[0] falls -> ABSENT, no HOLD entry.
REQ-039 SHALL cover: ACTIVE with run=0 -> led[0] toggles every 5 cycles; run=1 -> led[0]=0 steady; ABSENT -> led[0]=1.
REQ-040 SHALL cover: system_reset pulsed while channel 0 in WAIT -> next edge resetl=00, channel_reset=11, hpd=00, led=111.
